// File: rtl/spi_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg : shared FSM state encoding and op codes for the SPI transfer engine
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic OP_WR = 1'b0;
  localparam logic OP_RW = 1'b1;

endpackage

`default_nettype wire

// File: rtl/fifo.sv
// ----------------------------------------------------------------------------
// fifo : show-ahead synchronous FIFO, overflow/underflow requests are dropped
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO still lands when a pop frees a slot in the same cycle.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    if (do_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/spi_xfer_engine.sv
// ----------------------------------------------------------------------------
// spi_xfer_engine : FIFO-fed SPI master, modes 0-3, multi-word bursts
// Build option: define SPI_LOOPBACK_EN to loop mosi back into the receiver.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_xfer_engine
  import spi_pkg::*;
#(
  parameter int DATA       = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_CS     = 2,
  parameter int CLK_DIV    = 4,
  localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA-1:0]   tx_wdata,
  input  logic              tx_wr,
  output logic              tx_full,
  output logic [DATA-1:0]   rx_rdata,
  input  logic              rx_rd,
  output logic              rx_empty,
  input  logic              start,
  input  logic [15:0]       len,
  input  logic              op,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] scsn
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int EC_W  = $clog2(2 * DATA);
  localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA - 1);
  localparam logic [EC_W-1:0] PREV_EDGE = EC_W'(2 * DATA - 2);

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic              op_q, op_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [EC_W-1:0]   ec_q, ec_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [DATA-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA-2:0]   rx_sr_q, rx_sr_d;
  logic [NUM_CS-1:0] scsn_q, scsn_d;
  logic              done_q, done_d;

  logic              miso_int;
  logic              tick;
  logic              odd_edge;
  logic              last_edge;
  logic              sample_edge;
  logic              drive_edge;
  logic              last_sample;
  logic              load_ok;
  logic              tx_rd;
  logic              tx_empty;
  logic [DATA-1:0]   tx_rdata;
  logic              rx_wr;
  logic              rx_full;
  logic [DATA-1:0]   rx_wdata;

`ifdef SPI_LOOPBACK_EN
  assign miso_int = mosi_q;
`else
  assign miso_int = miso;
`endif

  fifo #(.WIDTH(DATA), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst),
    .wr(tx_wr), .wdata(tx_wdata), .full(tx_full),
    .rd(tx_rd), .rdata(tx_rdata), .empty(tx_empty)
  );

  fifo #(.WIDTH(DATA), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst),
    .wr(rx_wr), .wdata(rx_wdata), .full(rx_full),
    .rd(rx_rd), .rdata(rx_rdata), .empty(rx_empty)
  );

  // ec_q counts completed sclk edges in the word; edge number is ec_q+1.
  assign tick        = (div_q == DIV_W'(CLK_DIV - 1));
  assign odd_edge    = ~ec_q[0];
  assign last_edge   = (ec_q == LAST_EDGE);
  assign sample_edge = cpha_q ? ~odd_edge : odd_edge;
  assign drive_edge  = cpha_q ? odd_edge : (~odd_edge && !last_edge);
  assign last_sample = sample_edge && (ec_q == (cpha_q ? LAST_EDGE : PREV_EDGE));
  assign load_ok     = !tx_empty && !((op_q == OP_RW) && rx_full);
  assign rx_wdata    = {rx_sr_q, miso_int};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    op_d    = op_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    div_d   = div_q;
    ec_d    = ec_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    scsn_d  = scsn_q;
    done_d  = (state_q == ST_DONE);
    tx_rd   = 1'b0;
    rx_wr   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sclk_d = cpol;
        mosi_d = 1'b0;
        scsn_d = '1;
        if (start && (int'(cs_sel) < NUM_CS)) begin
          len_d  = len;
          op_d   = op;
          cpol_d = cpol;
          cpha_d = cpha;
          div_d  = '0;
          if (len == 16'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SETUP;
            scsn_d  = ~(NUM_CS'(1) << cs_sel);
          end
        end
      end

      ST_SETUP: begin
        sclk_d = cpol_q;
        if (tick) begin
          div_d   = '0;
          state_d = ST_LOAD;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      ST_LOAD: begin
        sclk_d = cpol_q;
        mosi_d = 1'b0;
        if (load_ok) begin
          tx_rd   = 1'b1;
          div_d   = '0;
          ec_d    = '0;
          state_d = ST_SHIFT;
          // cpha=0 presents the MSB a half-period ahead of the first edge.
          if (cpha_q) begin
            tx_sr_d = tx_rdata;
          end else begin
            mosi_d  = tx_rdata[DATA-1];
            tx_sr_d = {tx_rdata[DATA-2:0], 1'b0};
          end
        end
      end

      ST_SHIFT: begin
        if (!tick) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d  = '0;
          ec_d   = ec_q + EC_W'(1);
          sclk_d = ~sclk_q;
          if (sample_edge) rx_sr_d = rx_wdata[DATA-2:0];
          if (last_sample && (op_q == OP_RW)) rx_wr = 1'b1;
          if (drive_edge) begin
            mosi_d  = tx_sr_q[DATA-1];
            tx_sr_d = {tx_sr_q[DATA-2:0], 1'b0};
          end
          if (last_edge) begin
            mosi_d  = 1'b0;
            len_d   = len_q - 16'd1;
            state_d = (len_q == 16'd1) ? ST_HOLD : ST_LOAD;
          end
        end
      end

      ST_HOLD: begin
        sclk_d = cpol_q;
        if (tick) begin
          div_d   = '0;
          scsn_d  = '1;
          state_d = ST_DONE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      op_q    <= OP_WR;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      div_q   <= '0;
      ec_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      tx_sr_q <= '0;
      rx_sr_q <= '0;
      scsn_q  <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      op_q    <= op_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      div_q   <= div_d;
      ec_q    <= ec_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      tx_sr_q <= tx_sr_d;
      rx_sr_q <= rx_sr_d;
      scsn_q  <= scsn_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign scsn = scsn_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_xfer_engine.sv
// ----------------------------------------------------------------------------
// tb_spi_xfer_engine : directed bench with an RX scoreboard and SPI bus monitor
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_spi_xfer_engine;

  localparam int DATA       = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int NUM_CS     = 2;
  localparam int CLK_DIV    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA-1:0]   tx_wdata;
  logic              tx_wr;
  logic              tx_full;
  logic [DATA-1:0]   rx_rdata;
  logic              rx_rd;
  logic              rx_empty;
  logic              start;
  logic [15:0]       len;
  logic              op;
  logic [0:0]        cs_sel;
  logic              cpol;
  logic              cpha;
  logic              busy;
  logic              done;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic [NUM_CS-1:0] scsn;

  always #5 clk = ~clk;

  // External loopback: every received word must equal the word sent.
  assign miso = mosi;

  spi_xfer_engine #(
    .DATA(DATA), .FIFO_DEPTH(FIFO_DEPTH), .NUM_CS(NUM_CS), .CLK_DIV(CLK_DIV)
  ) dut (
    .clk(clk), .rst(rst),
    .tx_wdata(tx_wdata), .tx_wr(tx_wr), .tx_full(tx_full),
    .rx_rdata(rx_rdata), .rx_rd(rx_rd), .rx_empty(rx_empty),
    .start(start), .len(len), .op(op), .cs_sel(cs_sel),
    .cpol(cpol), .cpha(cpha),
    .busy(busy), .done(done),
    .sclk(sclk), .mosi(mosi), .miso(miso), .scsn(scsn)
  );

  int total = 0;
  int bad   = 0;
  logic [DATA-1:0] exp_q[$];

  int          rise_cnt;
  int          done_cnt;
  int          cs_fall [NUM_CS];
  logic [31:0] bits;
  logic        prev_sclk;
  logic        prev_mosi;
  logic [NUM_CS-1:0] prev_scsn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Bus monitor: sclk rising edges capture the mosi level held before the edge.
  initial begin
    rise_cnt  = 0;
    done_cnt  = 0;
    bits      = '0;
    prev_sclk = 1'b0;
    prev_mosi = 1'b0;
    prev_scsn = '1;
    for (int i = 0; i < NUM_CS; i++) cs_fall[i] = 0;
    forever begin
      @(negedge clk);
      if (!prev_sclk && sclk) begin
        rise_cnt++;
        bits = {bits[30:0], prev_mosi};
      end
      for (int i = 0; i < NUM_CS; i++)
        if (prev_scsn[i] && !scsn[i]) cs_fall[i]++;
      if (done === 1'b1) done_cnt++;
      prev_sclk = sclk;
      prev_mosi = mosi;
      prev_scsn = scsn;
    end
  end

  // RX scoreboard: pop and compare whenever the DUT presents a word.
  initial begin
    rx_rd = 1'b0;
    forever begin
      @(negedge clk);
      rx_rd = 1'b0;
      if (rst === 1'b0 && rx_empty === 1'b0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: actual=%0h required=none", rx_rdata);
        end else begin
          check("rx_data", {24'd0, rx_rdata}, {24'd0, exp_q.pop_front()});
        end
        rx_rd = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_tx(input logic [DATA-1:0] d);
    tx_wdata = d;
    tx_wr    = 1'b1;
    tick(1);
    tx_wr    = 1'b0;
  endtask

  task automatic set_mode(input logic p, input logic h);
    cpol = p;
    cpha = h;
    tick(3);
  endtask

  task automatic clr_mon();
    rise_cnt = 0;
    done_cnt = 0;
    bits     = '0;
    for (int i = 0; i < NUM_CS; i++) cs_fall[i] = 0;
  endtask

  task automatic start_xfer(input logic [15:0] l, input logic o, input logic [0:0] cs);
    len    = l;
    op     = o;
    cs_sel = cs;
    start  = 1'b1;
    tick(1);
    start  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick(1);
      n++;
    end
    if (done_cnt == 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: actual=no_done required=done within %0d cycles", name, budget);
    end
    tick(4);
  endtask

  initial begin
    rst = 1'b1; tx_wdata = '0; tx_wr = 1'b0; start = 1'b0; len = '0;
    op = 1'b0; cs_sel = '0; cpol = 1'b0; cpha = 1'b0;
    tick(3);
    check("rst_sclk", {31'd0, sclk}, 32'd0);
    check("rst_mosi", {31'd0, mosi}, 32'd0);
    check("rst_scsn", {30'd0, scsn}, 32'd3);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_tx_full", {31'd0, tx_full}, 32'd0);
    check("rst_rx_empty", {31'd0, rx_empty}, 32'd1);
    rst = 1'b0;
    tick(2);

    // Mode 0 read-write burst of two words.
    set_mode(1'b0, 1'b0);
    push_tx(8'hA5);
    push_tx(8'h3C);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    clr_mon();
    start_xfer(16'd2, 1'b1, 1'b0);
    wait_done("m0", 500);
    check("m0_sclk_rises", rise_cnt, 32'd16);
    check("m0_mosi_bits", {16'd0, bits[15:0]}, 32'h0000A53C);
    check("m0_cs0_falls", cs_fall[0], 32'd1);
    check("m0_cs1_falls", cs_fall[1], 32'd0);
    check("m0_done_pulses", done_cnt, 32'd1);
    check("m0_scsn_end", {30'd0, scsn}, 32'd3);
    check("m0_busy_end", {31'd0, busy}, 32'd0);

    // Mode 3 write-only single word.
    set_mode(1'b1, 1'b1);
    check("m3_sclk_idle", {31'd0, sclk}, 32'd1);
    push_tx(8'h81);
    clr_mon();
    start_xfer(16'd1, 1'b0, 1'b0);
    wait_done("m3", 500);
    check("m3_sclk_rises", rise_cnt, 32'd8);
    check("m3_mosi_bits", {24'd0, bits[7:0]}, 32'h81);
    check("m3_sclk_end", {31'd0, sclk}, 32'd1);
    check("m3_rx_empty", {31'd0, rx_empty}, 32'd1);
    check("m3_done_pulses", done_cnt, 32'd1);

    // TX underrun: stall in LOAD until the remaining words arrive.
    set_mode(1'b0, 1'b0);
    push_tx(8'h11);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    clr_mon();
    start_xfer(16'd3, 1'b1, 1'b0);
    tick(50);
    check("stall_busy", {31'd0, busy}, 32'd1);
    check("stall_scsn", {30'd0, scsn}, 32'd2);
    check("stall_sclk", {31'd0, sclk}, 32'd0);
    check("stall_mosi", {31'd0, mosi}, 32'd0);
    check("stall_rises", rise_cnt, 32'd8);
    push_tx(8'h22);
    push_tx(8'h33);
    wait_done("stall", 500);
    check("stall_total_rises", rise_cnt, 32'd24);
    check("stall_mosi_bits", {8'd0, bits[23:0]}, 32'h00112233);
    check("stall_done_pulses", done_cnt, 32'd1);

    // Reset in the middle of the first word on chip select 1.
    push_tx(8'hF0);
    push_tx(8'h0F);
    clr_mon();
    start_xfer(16'd2, 1'b1, 1'b1);
    begin
      int n = 0;
      while (rise_cnt < 4 && n < 200) begin
        tick(1);
        n++;
      end
    end
    check("mid_rises", rise_cnt, 32'd4);
    check("mid_scsn", {30'd0, scsn}, 32'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_async_scsn", {30'd0, scsn}, 32'd3);
    check("rst_async_busy", {31'd0, busy}, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(20);
    check("rst_no_done", done_cnt, 32'd0);
    check("rst_rx_empty", {31'd0, rx_empty}, 32'd1);
    check("rst_tx_not_full", {31'd0, tx_full}, 32'd0);

    // Zero-length command: done two cycles after start, no chip select.
    clr_mon();
    len    = 16'd0;
    op     = 1'b1;
    cs_sel = 1'b1;
    start  = 1'b1;
    tick(1);
    start  = 1'b0;
    check("len0_done_c1", {31'd0, done}, 32'd0);
    tick(1);
    check("len0_done_c2", {31'd0, done}, 32'd1);
    tick(1);
    check("len0_done_c3", {31'd0, done}, 32'd0);
    check("len0_scsn", {30'd0, scsn}, 32'd3);
    check("len0_cs0_falls", cs_fall[0], 32'd0);
    check("len0_cs1_falls", cs_fall[1], 32'd0);
    check("len0_rises", rise_cnt, 32'd0);

    // Start while busy is ignored.
    push_tx(8'h5A);
    clr_mon();
    start_xfer(16'd1, 1'b0, 1'b0);
    tick(6);
    check("busy_mid", {31'd0, busy}, 32'd1);
    start_xfer(16'd3, 1'b1, 1'b1);
    wait_done("busy_start", 500);
    tick(10);
    check("busy_done_pulses", done_cnt, 32'd1);
    check("busy_cs1_falls", cs_fall[1], 32'd0);
    check("busy_rises", rise_cnt, 32'd8);
    check("busy_idle_end", {31'd0, busy}, 32'd0);
    check("busy_rx_empty", {31'd0, rx_empty}, 32'd1);

    // Fill TX, overflow push must not disturb stored words.
    for (int i = 1; i <= FIFO_DEPTH; i++) push_tx(8'(i));
    check("fill_full", {31'd0, tx_full}, 32'd1);
    push_tx(8'hFF);
    check("ovf_full", {31'd0, tx_full}, 32'd1);
    for (int i = 1; i <= FIFO_DEPTH; i++) exp_q.push_back(8'(i));
    clr_mon();
    start_xfer(16'(FIFO_DEPTH), 1'b1, 1'b0);
    wait_done("fill", 2000);
    check("fill_rises", rise_cnt, 32'd64);
    check("fill_done_pulses", done_cnt, 32'd1);
    check("fill_tx_drained", {31'd0, tx_full}, 32'd0);

    tick(20);
    check("rx_pending", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
